// File: rtl/led7seg_scanner.sv
// led7seg_scanner: time-multiplexes four hex digits onto a shared active-low
// 7-segment bus with active-low anodes, dead time between digits and a
// once-per-frame input snapshot. Optional leading-zero blanking is compiled
// in when LED7SEG_LZB_EN is defined.
module led7seg_scanner #(
  parameter int SCAN_DIV  = 390,
  parameter int BLANK_CYC = 8
) (
  input  logic       I_CLK,
  input  logic       I_RESET_N,
  input  logic [3:0] I_DIGIT3,
  input  logic [3:0] I_DIGIT2,
  input  logic [3:0] I_DIGIT1,
  input  logic [3:0] I_DIGIT0,
  input  logic [3:0] I_DRVEN,
  input  logic [3:0] I_DOTS,
  output logic [6:0] O_SEG_N,
  output logic       O_DP_N,
  output logic [3:0] O_AN_N
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   snap_digits_reg;
  logic [3:0]    snap_en_reg;
  logic [3:0]    snap_dots_reg;
  logic [3:0]    snap_lz_reg;

  logic [15:0]   digits_in;
  logic [3:0]    lz_next;
  logic          wrap;
  logic          capture;
  logic [3:0]    cur_digit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign digits_in = {I_DIGIT3, I_DIGIT2, I_DIGIT1, I_DIGIT0};
  assign wrap      = (cnt_reg == CNT_LAST);
  // Last cycle of slot 0 is the frame boundary: latch the next frame's data.
  assign capture   = wrap && (idx_reg == 2'd0);

`ifdef LED7SEG_LZB_EN
  // A digit is a leading zero when it and every digit to its left are 0.
  // Digit 0 always stays visible so an all-zero value still shows "0".
  always_comb begin
    lz_next    = 4'b0000;
    lz_next[3] = (I_DIGIT3 == 4'd0);
    lz_next[2] = lz_next[3] && (I_DIGIT2 == 4'd0);
    lz_next[1] = lz_next[2] && (I_DIGIT1 == 4'd0);
  end
`else
  assign lz_next = 4'b0000;
`endif

  // 7-segment decode, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Slot counter and digit index: index steps 3->2->1->0->3 on each wrap.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      cnt_reg <= '0;
      idx_reg <= 2'd3;
    end else if (wrap) begin
      cnt_reg <= '0;
      idx_reg <= idx_reg - 2'd1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Frame snapshot: all inputs captured together so a frame never tears.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      snap_digits_reg <= '0;
      snap_en_reg     <= '0;
      snap_dots_reg   <= '0;
      snap_lz_reg     <= '0;
    end else if (capture) begin
      snap_digits_reg <= digits_in;
      snap_en_reg     <= I_DRVEN;
      snap_dots_reg   <= I_DOTS;
      snap_lz_reg     <= lz_next;
    end
  end

  assign cur_digit = snap_digits_reg[{idx_reg, 2'b00} +: 4];

  // Next output value from the current phase; dark unless in ON phase of an
  // enabled digit. A blanked leading zero still lights its dot if requested.
  always_comb begin
    an_next  = 4'hF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if ((cnt_reg >= BLANK_END) && snap_en_reg[idx_reg]) begin
      if (!snap_lz_reg[idx_reg]) begin
        an_next  = ~(4'b0001 << idx_reg);
        seg_next = decode(cur_digit);
        dp_next  = ~snap_dots_reg[idx_reg];
      end else if (snap_dots_reg[idx_reg]) begin
        an_next  = ~(4'b0001 << idx_reg);
        dp_next  = 1'b0;
      end
    end
  end

  // Registered outputs; asynchronous reset darkens the display immediately.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_AN_N  <= 4'hF;
      O_SEG_N <= 7'h7F;
      O_DP_N  <= 1'b1;
    end else begin
      O_AN_N  <= an_next;
      O_SEG_N <= seg_next;
      O_DP_N  <= dp_next;
    end
  end

endmodule

// File: tb/tb_led7seg_scanner.sv
// tb_led7seg_scanner: table-driven frame checks, hand sequences for reset and
// tearing, and randomized stimulus checked every cycle against a frame-level
// reference model. Honours LED7SEG_LZB_EN for the expected values.
module tb_led7seg_scanner;

  localparam int S = 8;       // SCAN_DIV
  localparam int B = 2;       // BLANK_CYC
  localparam int F = 4 * S;   // cycles per frame
  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d3, d2, d1, d0, drven, dots;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;

  always #5 clk = ~clk;

  led7seg_scanner #(.SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .I_CLK(clk), .I_RESET_N(rst_n),
    .I_DIGIT3(d3), .I_DIGIT2(d2), .I_DIGIT1(d1), .I_DIGIT0(d0),
    .I_DRVEN(drven), .I_DOTS(dots),
    .O_SEG_N(seg_n), .O_DP_N(dp_n), .O_AN_N(an_n)
  );

  int total = 0;
  int bad   = 0;
  int e;   // clock edges since reset release

  // Reference snapshot of one frame's data.
  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  en;
    logic [3:0]  dt;
    logic [3:0]  lz;
  } snap_t;
  snap_t msnap;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Table vector: inputs and expected {an,seg,dp} per slot during ON phase.
  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  en;
    logic [3:0]  dt;
    logic [47:0] exp;   // slot n at [12*n +: 12]
  } vec_t;
  vec_t vecs[$];

  function automatic snap_t take_snap();
    snap_t s;
    s.dig = {d3, d2, d1, d0};
    s.en  = drven;
    s.dt  = dots;
    s.lz  = 4'b0000;
`ifdef LED7SEG_LZB_EN
    for (int n = 1; n < 4; n++)
      s.lz[n] = ((s.dig >> (4 * n)) == 16'd0);
`endif
    return s;
  endfunction

  // Expected output in the cycle after position p of the frame sequence.
  function automatic logic [11:0] model_out(input int p, input snap_t s);
    int slot, ph;
    logic [3:0] an;
    slot = 3 - ((p / S) % 4);
    ph   = p % S;
    if (ph < B || !s.en[slot] || (s.lz[slot] && !s.dt[slot]))
      return DARK;
    an = 4'hF & ~(4'b0001 << slot);
    if (s.lz[slot])
      return {an, 7'h7F, 1'b0};
    return {an, dec[s.dig[4*slot +: 4]], ~s.dt[slot]};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s e=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
               name, e, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // One clock: check against model, then advance the model snapshot.
  task automatic step();
    @(posedge clk);
    #1;
    e++;
    chk("model", {an_n, seg_n, dp_n}, model_out(e - 1, msnap));
    if (e % F == 0) msnap = take_snap();
  endtask

  // Step at least once until e%F == r (bounded by one frame).
  task automatic step_until(input int r);
    step();
    for (int k = 0; k < F && (e % F) != r; k++) step();
  endtask

  task automatic set_in(input logic [15:0] dig, input logic [3:0] en, input logic [3:0] dt);
    {d3, d2, d1, d0} = dig;
    drven = en;
    dots  = dt;
  endtask

  function automatic logic [11:0] lit(input int slot, input logic [6:0] seg, input logic dp);
    logic [3:0] an;
    an = 4'hF & ~(4'b0001 << slot);
    return {an, seg, dp};
  endfunction

  initial begin
    rst_n = 1'b0;
    e = 0;
    msnap = '0;
    set_in(16'h0000, 4'h0, 4'h0);

    // Table of per-frame expectations.
    vecs.push_back('{16'h1234, 4'hF, 4'h0, {lit(3,7'h79,1), lit(2,7'h24,1), lit(1,7'h30,1), lit(0,7'h19,1)}});
    vecs.push_back('{16'h1234, 4'hA, 4'h0, {lit(3,7'h79,1), DARK, lit(1,7'h30,1), DARK}});
    vecs.push_back('{16'h8888, 4'hF, 4'h1, {lit(3,7'h00,1), lit(2,7'h00,1), lit(1,7'h00,1), lit(0,7'h00,0)}});
    vecs.push_back('{16'hABCD, 4'hF, 4'hA, {lit(3,7'h08,0), lit(2,7'h03,1), lit(1,7'h46,0), lit(0,7'h21,1)}});
    vecs.push_back('{16'hEF97, 4'h7, 4'hF, {DARK, lit(2,7'h0E,0), lit(1,7'h10,0), lit(0,7'h78,0)}});
`ifdef LED7SEG_LZB_EN
    vecs.push_back('{16'h0050, 4'hF, 4'h0, {DARK, DARK, lit(1,7'h12,1), lit(0,7'h40,1)}});
    vecs.push_back('{16'h0000, 4'hF, 4'h0, {DARK, DARK, DARK, lit(0,7'h40,1)}});
    vecs.push_back('{16'h0000, 4'hF, 4'h4, {DARK, lit(2,7'h7F,0), DARK, lit(0,7'h40,1)}});
`else
    vecs.push_back('{16'h0050, 4'hF, 4'h0, {lit(3,7'h40,1), lit(2,7'h40,1), lit(1,7'h12,1), lit(0,7'h40,1)}});
`endif

    // Reset state, then release away from the clock edge.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_init", {an_n, seg_n, dp_n}, DARK);
    #2 rst_n = 1'b1;

    // First frame after reset: dark even with inputs driven (model checks).
    set_in(16'h1234, 4'hF, 4'h0);
    step_until(0);
    chk("first_frame_snap_seen", {an_n, seg_n, dp_n}, DARK);

    // Table-driven frames.
    for (int v = 0; v < vecs.size(); v++) begin
      set_in(vecs[v].dig, vecs[v].en, vecs[v].dt);
      step_until(0);
      for (int j = 1; j <= F; j++) begin
        int slot, ph;
        step();
        slot = 3 - (j - 1) / S;
        ph   = (j - 1) % S;
        chk($sformatf("vec%0d", v), {an_n, seg_n, dp_n},
            (ph < B) ? DARK : vecs[v].exp[12*slot +: 12]);
      end
      $display("vec %0d digits=%h en=%h dots=%h checked", v, vecs[v].dig, vecs[v].en, vecs[v].dt);
    end

    // Tearing: change digit 0 during slot 2; current frame keeps the old value.
    set_in(16'h1234, 4'hF, 4'h0);
    step_until(0);
    step_until(0);
    step_until(S + 3);
    d0 = 4'hF;
    step_until(3 * S + B + 1);
    chk("tear_same_frame", {an_n, seg_n, dp_n}, {4'hE, 7'h19, 1'b1});
    step_until(0);
    step_until(3 * S + B + 1);
    chk("tear_next_frame", {an_n, seg_n, dp_n}, {4'hE, 7'h0E, 1'b1});
    $display("tearing sequence checked");

    // Randomized stimulus against the model.
    for (int k = 0; k < 10 * F; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        d3 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        d2 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        d1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        d0 = 4'($urandom);
        drven = 4'($urandom);
        dots  = 4'($urandom);
      end
      step();
    end
    $display("random run checked through edge %0d", e);

    // Asynchronous reset mid-ON phase of a lit slot.
    set_in(16'h1234, 4'hF, 4'h0);
    step_until(0);
    step_until(S + B + 2);
    chk("pre_reset_lit", {an_n, seg_n, dp_n}, {4'hB, 7'h24, 1'b1});
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {an_n, seg_n, dp_n}, DARK);
    @(posedge clk);
    #1;
    chk("reset_hold", {an_n, seg_n, dp_n}, DARK);
    #2 rst_n = 1'b1;
    e = 0;
    msnap = '0;
    repeat (2 * F) step();   // first frame dark, second lit (model)
    $display("reset sequence checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led7seg_scanner.md
Name: led7seg_scanner

Overview:
- Display stage directly downstream of the board control logic. Consumes four 4-bit digit codes, per-digit drive enables and per-digit dots.
- Time-multiplexes them onto one shared active-low 7-segment bus with active-low digit anodes.
- Inserts a ghost-suppression dead time between digits and snapshots its inputs once per frame so the display does not tear.

Parameters:
- SCAN_DIV, 390, clock cycles per digit slot (~1 kHz digit rate at ~390.6 kHz I_CLK); legal range >= 4.
- BLANK_CYC, 8, dead-time cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-1.

Ports:
- I_CLK  input  1  system clock.
- I_RESET_N  input  1  reset. One clock; reset is asynchronous and active-low.
- I_DIGIT3  input  4  code for leftmost digit (0-F).
- I_DIGIT2  input  4  code for digit 2.
- I_DIGIT1  input  4  code for digit 1.
- I_DIGIT0  input  4  code for rightmost digit.
- I_DRVEN  input  4  per-digit enable, bit n = digit n; 0 blanks that digit.
- I_DOTS  input  4  per-digit decimal point request, bit n = digit n.
- O_SEG_N  output  7  segments {g,f,e,d,c,b,a}, active-low.
- O_DP_N  output  1  decimal point, active-low.
- O_AN_N  output  4  digit anodes, bit n = digit n, active-low.

Behaviour:
- Reset (asynchronous assert, any time including mid-slot):
  - O_AN_N=4'hF, O_SEG_N=7'h7F, O_DP_N=1.
  - slot counter=0, digit index=3.
  - Snapshot registers all 0, including drive-enable snapshot 0, so the first frame after reset is fully dark.
- Slot counter: counts 0..SCAN_DIV-1, then wraps to 0. On the wrap edge the digit index advances 3->2->1->0->3.
- Snapshot: on the edge where counter==SCAN_DIV-1 and index==0, all four I_DIGITn, I_DRVEN and I_DOTS are captured together. The captured values are used for the entire following frame (slots 3,2,1,0). Input changes at any other time have no effect until the next snapshot.
- Phases within a slot:
  - BLANK: counter 0..BLANK_CYC-1.
  - ON: counter BLANK_CYC..SCAN_DIV-1.
- Outputs are registered from the current counter/index, with 1-cycle latency. The output in cycle k+1 reflects the phase at cycle k.
  - BLANK phase, or snapshot DRVEN[index]=0: O_AN_N=4'hF, O_SEG_N=7'h7F, O_DP_N=1.
  - ON phase with DRVEN[index]=1: O_AN_N has only bit index low; O_SEG_N=decode(snap digit[index]); O_DP_N=~DOTS[index].
- Invariant: at most one anode is low in any cycle. At least BLANK_CYC all-off cycles separate consecutive lit digits.
- Decode table (O_SEG_N hex):
  - digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - hex letters: A=08, b=03, C=46, d=21, E=06, F=0E
- Dots are independent of digit value. A dot on a disabled digit is not shown.
- Counter width = clog2(SCAN_DIV). No other arithmetic.

Optional Feature:
- Macro LED7SEG_LZB_EN enables leading-zero blanking.
- Defined:
  - At snapshot, each digit n in 3..1 is treated as disabled if its value is 0 and every higher digit is also 0 (or already blanked).
  - Digit 0 is never blanked by this rule.
  - A dot request still lights O_DP_N on a zero-blanked digit, with anode on and O_SEG_N=7F.
- Undefined: no suppression; zeros display as 40.

Test Plan:
- Reset: drive I_RESET_N=0 mid-ON phase -> O_AN_N=F, O_SEG_N=7F, O_DP_N=1 within the same cycle (asynchronous). After release, the first full frame is dark.
- SCAN_DIV=8, BLANK_CYC=2, digits 1,2,3,4, DRVEN=F, DOTS=0 -> from the second frame, each slot shows 2 cycles AN_N=F and then 6 cycles of the lit digit:
  - slot 3: AN_N=7, SEG_N=79
  - slot 2: AN_N=B, SEG_N=24
  - slot 1: AN_N=D, SEG_N=30
  - slot 0: AN_N=E, SEG_N=19
- DRVEN=4'b1010 -> slots 2 and 0 hold AN_N=F, SEG_N=7F for all 8 cycles. Slots 3 and 1 are lit normally.
- Tearing: change I_DIGIT0 from 4 to F during slot 2 -> slot 0 of the same frame still shows 19. The next frame shows 0E.
- DOTS=4'b0001, digits 8,8,8,8 -> O_DP_N=0 only during slot-0 ON cycles. SEG_N=00 in every ON phase.
- With LED7SEG_LZB_EN:
  - digits 0,0,5,0 -> slots 3 and 2 dark, slot 1 shows 12, slot 0 shows 40.
  - digits 0,0,0,0 -> only slot 0 lit with 40.
